// File: rtl/gfx_pkg.sv
// Shared constants and pixel types for the bounce graphics stage.
package gfx_pkg;

  localparam int HPIXELS = 640;
  localparam int VPIXELS = 480;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t PALETTE [8] = '{
    '{3'd7, 3'd0, 2'd0},
    '{3'd0, 3'd7, 2'd0},
    '{3'd0, 3'd0, 2'd3},
    '{3'd7, 3'd7, 2'd0},
    '{3'd0, 3'd7, 2'd3},
    '{3'd7, 3'd0, 2'd3},
    '{3'd7, 3'd3, 2'd0},
    '{3'd3, 3'd3, 2'd3}
  };

  localparam rgb332_t BORDER_COLOR = '{3'd7, 3'd7, 2'd3};
  localparam rgb332_t BG_COLOR     = '{3'd0, 3'd0, 2'd1};

endpackage

// File: rtl/bounce_gfx_if.sv
// Pixel-counter inputs and colour/status outputs of the bounce graphics stage.
interface bounce_gfx_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       pause;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_tick;
  logic [7:0] bounce_count;
  logic [9:0] box_x;
  logic [9:0] box_y;

  modport master (
    output hc, vc, pause,
    input  red, green, blue, frame_tick, bounce_count, box_x, box_y
  );

  modport slave (
    input  hc, vc, pause,
    output red, green, blue, frame_tick, bounce_count, box_x, box_y
  );
endinterface

// File: rtl/bounce_axis.sv
// One axis of box motion: position, direction and bounce detection.
module bounce_axis #(
  parameter int LIMIT     = 640,
  parameter int SIZE      = 32,
  parameter int BORDER    = 4,
  parameter int SPEED     = 2,
  parameter int RESET_POS = 304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] MAX_P = 11'(LIMIT - BORDER - SIZE);
  localparam logic [10:0] MIN_P = 11'(BORDER);
  localparam logic [10:0] SPD   = 11'(SPEED);

  logic [9:0] pos_q, pos_d;
  logic       dir_q, dir_d;
  logic       hit;
  logic [10:0] pos11;

  // Next position: move by SPEED, clamp to the wall and reverse on contact.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    hit   = 1'b0;
    pos11 = {1'b0, pos_q};
    if (dir_q) begin
      if (pos11 + SPD >= MAX_P) begin
        pos_d = MAX_P[9:0];
        dir_d = 1'b0;
        hit   = 1'b1;
      end else begin
        pos_d = 10'(pos11 + SPD);
      end
    end else begin
      if (pos11 <= MIN_P + SPD) begin
        pos_d = MIN_P[9:0];
        dir_d = 1'b1;
        hit   = 1'b1;
      end else begin
        pos_d = 10'(pos11 - SPD);
      end
    end
    if (!step) begin
      pos_d = pos_q;
      dir_d = dir_q;
      hit   = 1'b0;
    end
  end

  // Position/direction register; direction 1 means moving toward larger values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= 10'(RESET_POS);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos    = pos_q;
  assign bounce = hit;

endmodule

// File: rtl/bounce_gfx.sv
// Border, background and bouncing box renderer driven by VGA pixel counters.
module bounce_gfx
  import gfx_pkg::*;
#(
  parameter int HPIX     = HPIXELS,
  parameter int VPIX     = VPIXELS,
  parameter int BOX_SIZE = 32,
  parameter int BORDER   = 4,
  parameter int SPEED_X  = 2,
  parameter int SPEED_Y  = 1
) (
  input  logic        vgaclk,
  input  logic        rst,
  bounce_gfx_if.slave bus
);

  localparam logic [10:0] H_VIS = 11'(HPIX);
  localparam logic [10:0] V_VIS = 11'(VPIX);
  localparam logic [10:0] BRD   = 11'(BORDER);
  localparam logic [10:0] H_BRD = 11'(HPIX - BORDER);
  localparam logic [10:0] V_BRD = 11'(VPIX - BORDER);
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);

  logic       upd, step;
  logic [9:0] box_x, box_y;
  logic       bounce_x, bounce_y;

  logic [7:0] count_q, count_d;
  logic       tick_q, tick_d;
  rgb332_t    pix_q, pix_d;

  logic [10:0] hc11, vc11, bx11, by11;

  // Positions advance only at the start of the first blank line.
  assign upd  = (bus.hc == 10'd0) && ({1'b0, bus.vc} == V_VIS);
  assign step = upd && !bus.pause;

  bounce_axis #(
    .LIMIT(HPIX), .SIZE(BOX_SIZE), .BORDER(BORDER),
    .SPEED(SPEED_X), .RESET_POS((HPIX - BOX_SIZE) / 2)
  ) u_axis_x (
    .clk(vgaclk), .rst(rst), .step(step), .pos(box_x), .bounce(bounce_x)
  );

  bounce_axis #(
    .LIMIT(VPIX), .SIZE(BOX_SIZE), .BORDER(BORDER),
    .SPEED(SPEED_Y), .RESET_POS((VPIX - BOX_SIZE) / 2)
  ) u_axis_y (
    .clk(vgaclk), .rst(rst), .step(step), .pos(box_y), .bounce(bounce_y)
  );

  // Frame strobe, bounce counting (a corner counts once) and pixel classification.
  always_comb begin
    tick_d  = upd;
    count_d = count_q;
    if (bounce_x || bounce_y) count_d = count_q + 8'd1;

    hc11 = {1'b0, bus.hc};
    vc11 = {1'b0, bus.vc};
    bx11 = {1'b0, box_x};
    by11 = {1'b0, box_y};

    pix_d = BG_COLOR;
    if (hc11 >= H_VIS || vc11 >= V_VIS) begin
      pix_d = '0;
    end else if (hc11 < BRD || hc11 >= H_BRD || vc11 < BRD || vc11 >= V_BRD) begin
      pix_d = BORDER_COLOR;
    end else if (hc11 >= bx11 && hc11 < bx11 + BOX &&
                 vc11 >= by11 && vc11 < by11 + BOX) begin
      pix_d = PALETTE[count_q[2:0]];
    end
  end

  // Output and counter registers.
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
      tick_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.red          = pix_q.r;
  assign bus.green        = pix_q.g;
  assign bus.blue         = pix_q.b;
  assign bus.frame_tick   = tick_q;
  assign bus.bounce_count = count_q;
  assign bus.box_x        = box_x;
  assign bus.box_y        = box_y;

endmodule

// File: tb/tb_bounce_gfx.sv
// Self-checking bench for bounce_gfx with a reference model and scoreboard queues.
module tb_bounce_gfx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bounce_gfx_if bus();

  bounce_gfx dut (.vgaclk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  int mx, my, mcount;
  bit mdx, mdy;

  logic [27:0] exp_q[$];   // {box_x, box_y, bounce_count}
  logic [27:0] act_q[$];
  logic [7:0]  pix_exp_q[$];
  int          tick_hi, tick_lo;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_axis(input int lim, input int spd, inout int p, inout bit d,
                            output bit hit);
    int mx_p, mn_p;
    mx_p = lim - 4 - 32;
    mn_p = 4;
    hit = 0;
    if (d) begin
      if (p + spd >= mx_p) begin p = mx_p; d = 0; hit = 1; end
      else p = p + spd;
    end else begin
      if (p <= mn_p + spd) begin p = mn_p; d = 1; hit = 1; end
      else p = p - spd;
    end
  endtask

  task automatic model_reset();
    mx = 304; my = 224; mdx = 1; mdy = 1; mcount = 0;
  endtask

  // Drive one update strobe plus one following blank cycle; record expectation and result.
  task automatic do_strobe(input bit paused);
    bit hx, hy;
    bus.pause = paused;
    bus.hc = 10'd0;
    bus.vc = 10'd480;
    if (!paused) begin
      model_axis(640, 2, mx, mdx, hx);
      model_axis(480, 1, my, mdy, hy);
      if (hx || hy) mcount = (mcount + 1) % 256;
    end
    exp_q.push_back({10'(mx), 10'(my), 8'(mcount)});
    @(posedge clk); #1;
    act_q.push_back({bus.box_x, bus.box_y, bus.bounce_count});
    if (bus.frame_tick === 1'b1) tick_hi++;
    bus.hc = 10'd1;
    @(posedge clk); #1;
    if (bus.frame_tick === 1'b0) tick_lo++;
    bus.pause = 1'b0;
  endtask

  task automatic do_reset();
    bus.hc = 10'd100; bus.vc = 10'd100; bus.pause = 1'b0;
    rst = 1'b1;
    #7;
    rst = 1'b0;
    model_reset();
    exp_q.delete(); act_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    bus.hc = 10'd400; bus.vc = 10'd300;
    @(posedge clk); #1;
    got = {bus.red, bus.green, bus.blue};
    tests++;
    if (got !== 8'h01) begin
      failed++; $display("FAIL pre_reset_bg: got %h required %h", got, 8'h01);
    end
    rst = 1'b1;
    #1;
    got = {bus.red, bus.green, bus.blue};
    tests++;
    if (got !== 8'h00) begin
      failed++; $display("FAIL reset_rgb_async: got %h required 00", got);
    end
    tests++;
    if (bus.box_x !== 10'd304 || bus.box_y !== 10'd224) begin
      failed++; $display("FAIL reset_pos: got %0d,%0d required 304,224", bus.box_x, bus.box_y);
    end
    tests++;
    if (bus.bounce_count !== 8'd0 || bus.frame_tick !== 1'b0) begin
      failed++; $display("FAIL reset_count_tick: got %0d,%b required 0,0",
                         bus.bounce_count, bus.frame_tick);
    end
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pixel_map();
    logic [9:0] hs [5] = '{10'd0, 10'd320, 10'd100, 10'd700, 10'd336};
    logic [9:0] vs [5] = '{10'd0, 10'd240, 10'd100, 10'd10, 10'd240};
    logic [7:0] es [5] = '{8'hFF, 8'hE0, 8'h01, 8'h00, 8'h01};
    logic [7:0] got, e;
    for (int i = 0; i < 5; i++) begin
      bus.hc = hs[i]; bus.vc = vs[i];
      pix_exp_q.push_back(es[i]);
      @(posedge clk); #1;
      got = {bus.red, bus.green, bus.blue};
      e = pix_exp_q.pop_front();
      tests++;
      if (got !== e) begin
        failed++; $display("FAIL pixel_%0d_%0d: got %h required %h", hs[i], vs[i], got, e);
      end
    end
  endtask

  task automatic test_motion();
    logic [27:0] e, a;
    tick_hi = 0; tick_lo = 0;
    do_strobe(1'b0);
    e = exp_q.pop_front(); a = act_q.pop_front();
    tests++;
    if (a !== e || a[27:18] !== 10'd306 || a[17:8] !== 10'd225) begin
      failed++; $display("FAIL motion_one: got %h required %h (306,225)", a, e);
    end
    tests++;
    if (tick_hi !== 1 || tick_lo !== 1) begin
      failed++; $display("FAIL frame_tick_pulse: got hi=%0d lo=%0d required 1,1", tick_hi, tick_lo);
    end
  endtask

  task automatic test_x_bounce();
    logic [27:0] e, a;
    logic [7:0] got;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 150; i++) do_strobe(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a !== e) bad++;
    end
    tests++;
    if (bad != 0 || a !== {10'd604, 10'd374, 8'd1}) begin
      failed++; $display("FAIL x_bounce: got %h required %h, %0d step errors",
                         a, {10'd604, 10'd374, 8'd1}, bad);
    end
    bus.hc = 10'd610; bus.vc = 10'd380;
    @(posedge clk); #1;
    got = {bus.red, bus.green, bus.blue};
    tests++;
    if (got !== 8'h1C) begin
      failed++; $display("FAIL bounce_colour: got %h required 1c", got);
    end
    do_strobe(1'b0);
    e = exp_q.pop_front(); a = act_q.pop_front();
    tests++;
    if (a !== e || a[27:18] !== 10'd602) begin
      failed++; $display("FAIL x_reverse: got %0d required 602", a[27:18]);
    end
  endtask

  task automatic test_pause();
    logic [27:0] e, a;
    int bad;
    bad = 0;
    tick_hi = 0;
    for (int i = 0; i < 3; i++) do_strobe(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a !== e || a !== {10'd602, 10'd375, 8'd1}) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++; $display("FAIL pause_hold: got %h required %h", a, {10'd602, 10'd375, 8'd1});
    end
    tests++;
    if (tick_hi !== 3) begin
      failed++; $display("FAIL pause_ticks: got %0d required 3", tick_hi);
    end
  endtask

  task automatic force_x(input logic [9:0] v);
    force dut.u_axis_x.pos_q = v;
    #1;
    release dut.u_axis_x.pos_q;
    mx = v;
  endtask

  task automatic test_corner();
    logic [27:0] e, a;
    do_reset();
    force_x(10'd602);
    force dut.u_axis_y.pos_q = 10'd443;
    #1;
    release dut.u_axis_y.pos_q;
    my = 443;
    do_strobe(1'b0);
    e = exp_q.pop_front(); a = act_q.pop_front();
    tests++;
    if (a !== e || a !== {10'd604, 10'd444, 8'd1}) begin
      failed++; $display("FAIL corner_once: got %h required %h", a, {10'd604, 10'd444, 8'd1});
    end
  endtask

  task automatic test_wrap();
    logic [27:0] e, a;
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      force_x(mdx ? 10'd602 : 10'd6);
      do_strobe(1'b0);
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a !== e) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++; $display("FAIL wrap_steps: %0d step errors, last got %h required %h", bad, a, e);
    end
    tests++;
    if (bus.bounce_count !== 8'd0) begin
      failed++; $display("FAIL wrap_zero: got %0d required 0", bus.bounce_count);
    end
  endtask

  initial begin
    bus.hc = 10'd0; bus.vc = 10'd0; bus.pause = 1'b0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_pixel_map();
    test_motion();
    test_x_bounce();
    test_pause();
    test_corner();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
